// File: rtl/track_smoother_pkg.sv
// ============================================================================
// Module   : track_pkg
// Purpose  : Shared types, state encoding and default geometry for the
//            track_smoother block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package track_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOST    = 2'd3
  } track_state_t;

  typedef logic [9:0]         coord_t;
  typedef logic signed [10:0] sdiff_t;

  localparam int c_VGA_WIDTH      = 640;
  localparam int c_VGA_HEIGHT     = 480;
  localparam int c_TEMPLATE_WIDTH = 32;
  localparam int c_ALPHA_SHIFT    = 2;
  localparam int c_MAX_JUMP       = 64;
  localparam int c_LOST_COUNT     = 8;

  // 12-bit signed input leaves headroom for filter overshoot below zero.
  function automatic coord_t clamp_coord(input logic signed [11:0] v,
                                         input coord_t lo,
                                         input coord_t hi);
    logic signed [11:0] lo_s;
    logic signed [11:0] hi_s;
    logic [11:0]        v_u;
    lo_s = $signed({2'b00, lo});
    hi_s = $signed({2'b00, hi});
    v_u  = v;
    if (v < lo_s)      return lo;
    else if (v > hi_s) return hi;
    else               return v_u[9:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/track_smoother_ema_axis.sv
// ============================================================================
// Module   : ema_axis
// Purpose  : One axis of the box-centre update: snap or EMA step, clamped,
//            plus |peak - cur| for the jump gate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ema_axis
  import track_pkg::*;
#(
  parameter int ALPHA_SHIFT = c_ALPHA_SHIFT
) (
  input  coord_t      cur,
  input  coord_t      peak,
  input  logic        snap,
  input  logic        filter,
  input  coord_t      min_v,
  input  coord_t      max_v,
  output coord_t      nxt,
  output logic [10:0] abs_diff
);

  sdiff_t             w_diff;
  sdiff_t             w_step;
  sdiff_t             w_neg;
  logic signed [11:0] w_filt;
  logic signed [11:0] w_snap;

  assign w_diff = sdiff_t'({1'b0, peak}) - sdiff_t'({1'b0, cur});
  // Arithmetic shift floors toward minus infinity, matching the EMA weight.
  assign w_step = w_diff >>> ALPHA_SHIFT;
  assign w_neg  = -w_diff;
  assign w_filt = $signed({2'b00, cur}) + $signed({w_step[10], w_step});
  assign w_snap = $signed({2'b00, peak});

  assign abs_diff = w_diff[10] ? w_neg : w_diff;

  always_comb begin
    nxt = cur;
    if (snap)
      nxt = clamp_coord(w_snap, min_v, max_v);
    else if (filter)
      nxt = clamp_coord(w_filt, min_v, max_v);
  end

endmodule

`default_nettype wire

// File: rtl/track_smoother.sv
// ============================================================================
// Module   : track_smoother
// Purpose  : Gates correlator peaks by score/jump and produces a smoothed,
//            clamped face-box centre with lock/lost status.
//            Optional macro TRACK_SMOOTHER_HYST_EN raises the re-acquire
//            threshold to score_thresh * 1.25.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module track_smoother
  import track_pkg::*;
#(
  parameter int VGA_WIDTH      = c_VGA_WIDTH,
  parameter int VGA_HEIGHT     = c_VGA_HEIGHT,
  parameter int TEMPLATE_WIDTH = c_TEMPLATE_WIDTH,
  parameter int ALPHA_SHIFT    = c_ALPHA_SHIFT,
  parameter int MAX_JUMP       = c_MAX_JUMP,
  parameter int LOST_COUNT     = c_LOST_COUNT
) (
  input  logic        GCLK,
  input  logic        reset,
  input  logic        tracking_mode,
  input  logic        peak_valid,
  input  logic [9:0]  peak_x,
  input  logic [9:0]  peak_y,
  input  logic [15:0] peak_score,
  input  logic [15:0] score_thresh,
  output logic [9:0]  c_x,
  output logic [9:0]  c_y,
  output logic        pos_valid,
  output logic        locked,
  output logic        lost
);

  localparam int     MISS_W  = $clog2(LOST_COUNT + 1);
  localparam coord_t c_X_MIN = coord_t'(TEMPLATE_WIDTH / 2);
  localparam coord_t c_X_MAX = coord_t'(VGA_WIDTH - 1 - TEMPLATE_WIDTH / 2);
  localparam coord_t c_Y_MIN = coord_t'(TEMPLATE_WIDTH / 2);
  localparam coord_t c_Y_MAX = coord_t'(VGA_HEIGHT - 1 - TEMPLATE_WIDTH / 2);
  localparam coord_t c_X_RST = coord_t'(VGA_WIDTH / 2);
  localparam coord_t c_Y_RST = coord_t'(VGA_HEIGHT / 2);

  track_state_t      r_state, w_state_n;
  logic [MISS_W-1:0] r_miss, w_miss_n, w_miss_inc;
  coord_t            r_c_x, r_c_y;
  coord_t            w_nx, w_ny;
  logic              r_pos_valid, r_locked, r_lost;
  logic              w_snap, w_filter;
  logic [10:0]       w_abs_x, w_abs_y;
  logic [16:0]       w_acq_thresh;
  logic              w_score_ok, w_acq_ok, w_jump_ok;

`ifdef TRACK_SMOOTHER_HYST_EN
  assign w_acq_thresh = {1'b0, score_thresh} + {3'b000, score_thresh[15:2]};
`else
  assign w_acq_thresh = {1'b0, score_thresh};
`endif

  assign w_score_ok = peak_score >= score_thresh;
  assign w_acq_ok   = {1'b0, peak_score} >= w_acq_thresh;
  assign w_jump_ok  = (w_abs_x <= 11'(MAX_JUMP)) && (w_abs_y <= 11'(MAX_JUMP));
  assign w_miss_inc = r_miss + MISS_W'(1);

  ema_axis #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_axis_x (
    .cur      (r_c_x),
    .peak     (peak_x),
    .snap     (w_snap),
    .filter   (w_filter),
    .min_v    (c_X_MIN),
    .max_v    (c_X_MAX),
    .nxt      (w_nx),
    .abs_diff (w_abs_x)
  );

  ema_axis #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_axis_y (
    .cur      (r_c_y),
    .peak     (peak_y),
    .snap     (w_snap),
    .filter   (w_filter),
    .min_v    (c_Y_MIN),
    .max_v    (c_Y_MAX),
    .nxt      (w_ny),
    .abs_diff (w_abs_y)
  );

  always_comb begin
    w_state_n = r_state;
    w_miss_n  = r_miss;
    w_snap    = 1'b0;
    w_filter  = 1'b0;
    // Dropping the mode overrides everything, including a coincident peak.
    if (!tracking_mode) begin
      w_state_n = IDLE;
      w_miss_n  = '0;
    end else begin
      unique case (r_state)
        IDLE: w_state_n = ACQUIRE;
        ACQUIRE, LOST: begin
          if (peak_valid && w_acq_ok) begin
            w_snap    = 1'b1;
            w_state_n = TRACK;
            w_miss_n  = '0;
          end
        end
        TRACK: begin
          if (peak_valid) begin
            if (w_score_ok && w_jump_ok) begin
              w_filter = 1'b1;
              w_miss_n = '0;
            end else if (w_miss_inc == MISS_W'(LOST_COUNT)) begin
              w_state_n = LOST;
              w_miss_n  = '0;
            end else begin
              w_miss_n = w_miss_inc;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_miss      <= '0;
      r_c_x       <= c_X_RST;
      r_c_y       <= c_Y_RST;
      r_pos_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_miss      <= w_miss_n;
      r_c_x       <= w_nx;
      r_c_y       <= w_ny;
      r_pos_valid <= w_snap | w_filter;
      r_locked    <= (w_state_n == TRACK);
      r_lost      <= (w_state_n == LOST);
    end
  end

  assign c_x       = r_c_x;
  assign c_y       = r_c_y;
  assign pos_valid = r_pos_valid;
  assign locked    = r_locked;
  assign lost      = r_lost;

endmodule

`default_nettype wire
